pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its duty cycle as an 8-bit value (0–255) and its period in clock cycles. This is the receive-side counterpart of the PWM generator: it closes the loop on a board-level PWM line, for example to verify a switch-selected duty or to decode an external PWM source. It sits between a board input pin and any consumer of the recovered duty value, such as the LED or display logic.

---
 rtl/pwm_capture.sv | 136 +++++++++++++
 tb/tb_pwm_capture.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: measures an external PWM line and reports its duty (0-255)
// and its period in clock cycles. Duty is found with an 8-step restoring
// division of high time by period, one quotient bit per clock.
module pwm_capture #(
    parameter int CNT_W   = 24,
    parameter int TIMEOUT = 16777215
) (
    input  logic             CLOCK_50,
    input  logic             RESET_N,
    input  logic             PWM_IN,
    output logic [7:0]       DUTY,
    output logic [CNT_W-1:0] PERIOD,
    output logic             VALID,
    output logic             STUCK
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, MEASURE, DIVIDE} state_t;

    state_t           state;
    logic             sync1, pwm_s, prev;
    logic             rise, timeout, to_seen;
    logic [CNT_W-1:0] per_cnt, high_cnt, p;
    logic [CNT_W:0]   rem, rem_sh, rem_nxt;
    logic [7:0]       q, q_nxt;
    logic [2:0]       iter;
    logic             ovf, ge;

    assign rise    = pwm_s & ~prev;
    // Fire once per stuck episode; to_seen is re-armed by the next rise.
    assign timeout = (per_cnt == TO_VAL) && !to_seen;

    // Two-flop synchronizer plus a delayed copy for edge detection.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= 1'b0;
            pwm_s <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= PWM_IN;
            pwm_s <= sync1;
            prev  <= pwm_s;
        end
    end

    // Period and high-time counters restart on every rise, in every state.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            per_cnt  <= '0;
            high_cnt <= '0;
            to_seen  <= 1'b0;
        end else begin
            if (rise)
                per_cnt <= CNT_W'(1);
            else if (per_cnt != TO_VAL)
                per_cnt <= per_cnt + CNT_W'(1);

            // Saturate too, so a line held high cannot wrap the counter.
            if (rise)
                high_cnt <= CNT_W'(1);
            else if (pwm_s && high_cnt != TO_VAL)
                high_cnt <= high_cnt + CNT_W'(1);

            if (rise)
                to_seen <= 1'b0;
            else if (timeout)
                to_seen <= 1'b1;
        end
    end

    // One restoring-division step: shift remainder, subtract period if it fits.
    always_comb begin
        rem_sh  = rem << 1;
        ge      = (rem_sh >= {1'b0, p});
        rem_nxt = ge ? (rem_sh - {1'b0, p}) : rem_sh;
        q_nxt   = {q[6:0], ge};
    end

    // Control FSM: arm, latch a sample, divide, publish; timeout overrides all.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= IDLE;
            p      <= '0;
            rem    <= '0;
            q      <= '0;
            iter   <= '0;
            ovf    <= 1'b0;
            DUTY   <= '0;
            PERIOD <= '0;
            VALID  <= 1'b0;
            STUCK  <= 1'b0;
        end else begin
            VALID <= 1'b0;
            if (timeout) begin
                STUCK  <= 1'b1;
                DUTY   <= pwm_s ? 8'hFF : 8'h00;
                PERIOD <= '0;
                VALID  <= 1'b1;
                state  <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        // First rise only starts a period; nothing to report yet.
                        if (rise) state <= MEASURE;
                    end
                    MEASURE: begin
                        if (rise) begin
                            p     <= per_cnt;
                            rem   <= {1'b0, high_cnt};
                            q     <= '0;
                            iter  <= '0;
                            ovf   <= (high_cnt >= per_cnt);
                            state <= DIVIDE;
                        end
                    end
                    DIVIDE: begin
                        // Rises seen here are dropped; counters restart on their own.
                        rem  <= rem_nxt;
                        q    <= q_nxt;
                        iter <= iter + 3'd1;
                        if (iter == 3'd7) begin
                            DUTY   <= ovf ? 8'hFF : q_nxt;
                            PERIOD <= p;
                            VALID  <= 1'b1;
                            STUCK  <= 1'b0;
                            state  <= MEASURE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: a scoreboard of expected (duty, period, stuck, cycle)
// results is filled as PWM edges are driven and drained on every VALID.
module tb_pwm_capture;

    logic        clk, rst_n, pwm;
    logic [7:0]  duty_a, duty_b;
    logic [23:0] per_a, per_b;
    logic        valid_a, valid_b, stuck_a, stuck_b;

    // Instance A has a short timeout for stuck tests; B keeps the default
    // so a 1000-cycle period can be measured.
    pwm_capture #(.CNT_W(24), .TIMEOUT(1000)) dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .PWM_IN(pwm),
        .DUTY(duty_a), .PERIOD(per_a), .VALID(valid_a), .STUCK(stuck_a));

    pwm_capture #(.CNT_W(24)) dut_b (
        .CLOCK_50(clk), .RESET_N(rst_n), .PWM_IN(pwm),
        .DUTY(duty_b), .PERIOD(per_b), .VALID(valid_b), .STUCK(stuck_b));

    logic        sel_b;
    logic [7:0]  d_m;
    logic [23:0] p_m;
    logic        v_m, s_m;
    assign d_m = sel_b ? duty_b  : duty_a;
    assign p_m = sel_b ? per_b   : per_a;
    assign v_m = sel_b ? valid_b : valid_a;
    assign s_m = sel_b ? stuck_b : stuck_a;

    typedef struct {
        int duty;
        int period;
        int stuck;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks, failures;
    int   cyc;
    bit   in_meas;
    int   free_at;
    int   rel_cyc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard drain: every VALID must match the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && v_m) begin
            if (sb.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_valid cyc=%0d duty=%0d period=%0d stuck=%0d",
                         cyc, d_m, p_m, s_m);
            end else begin
                e = sb.pop_front();
                checks++;
                if (int'(d_m) !== e.duty) begin
                    failures++;
                    $display("FAIL valid_duty cyc=%0d got=%0d exp=%0d", cyc, d_m, e.duty);
                end
                checks++;
                if (int'(p_m) !== e.period) begin
                    failures++;
                    $display("FAIL valid_period cyc=%0d got=%0d exp=%0d", cyc, p_m, e.period);
                end
                checks++;
                if (int'(s_m) !== e.stuck) begin
                    failures++;
                    $display("FAIL valid_stuck cyc=%0d got=%0d exp=%0d", cyc, s_m, e.stuck);
                end
                checks++;
                if (cyc !== e.cyc) begin
                    failures++;
                    $display("FAIL valid_timing got_cyc=%0d exp_cyc=%0d", cyc, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pwm   = 1'b0;
        tick(3);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        in_meas = 1'b0;
        free_at = 0;
    endtask

    // Expected-result model for a rise driven now: the first rise after
    // idle only arms; later rises are sampled unless a divide is running.
    task automatic note_rise(input int per, input int dq);
        if (!in_meas) begin
            in_meas = 1'b1;
        end else if (cyc >= free_at) begin
            sb.push_back('{dq, per, 0, cyc + 11});
            free_at = cyc + 9;
        end
    endtask

    task automatic stream(input int per, input int hi, input int n, input int dq);
        for (int i = 0; i < n; i++) begin
            note_rise(per, dq);
            pwm = 1'b1;
            tick(hi);
            pwm = 1'b0;
            tick(per - hi);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (duty_a !== 8'd0) begin failures++; $display("FAIL reset_duty got=%0d exp=0", duty_a); end
        checks++;
        if (per_a !== 24'd0) begin failures++; $display("FAIL reset_period got=%0d exp=0", per_a); end
        checks++;
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0d exp=0", valid_a); end
        checks++;
        if (stuck_a !== 1'b0) begin failures++; $display("FAIL reset_stuck got=%0d exp=0", stuck_a); end
        tick(20);
    endtask

    task automatic test_duty_quarter();
        do_reset();
        stream(256, 64, 5, 64);
        tick(30);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL quarter_pending got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_duty_half();
        do_reset();
        stream(256, 128, 4, 128);
        tick(30);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL half_pending got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_long_period();
        sel_b = 1'b1;
        do_reset();
        stream(1000, 1, 3, 0);
        tick(30);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL long_pending got=%0d exp=0", sb.size()); sb.delete(); end
        do_reset();
        sel_b = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        stream(3, 1, 30, 85);
        tick(30);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL short_pending got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_stuck_low();
        do_reset();
        sb.push_back('{0, 0, 1, rel_cyc + 1001});
        tick(2500);
        in_meas = 1'b0;
        checks++;
        if (stuck_a !== 1'b1) begin failures++; $display("FAIL stuck_low_level got=%0d exp=1", stuck_a); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL stuck_low_pending got=%0d exp=0", sb.size()); sb.delete(); end
        stream(256, 64, 4, 64);
        tick(30);
        checks++;
        if (stuck_a !== 1'b0) begin failures++; $display("FAIL stuck_clear got=%0d exp=0", stuck_a); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL recover_pending got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_stuck_high();
        int c0;
        do_reset();
        stream(256, 64, 3, 64);
        note_rise(256, 64);
        c0 = cyc;
        sb.push_back('{255, 0, 1, c0 + 1003});
        pwm = 1'b1;
        tick(2500);
        in_meas = 1'b0;
        checks++;
        if (stuck_a !== 1'b1) begin failures++; $display("FAIL stuck_high_level got=%0d exp=1", stuck_a); end
        checks++;
        if (duty_a !== 8'd255) begin failures++; $display("FAIL stuck_high_duty got=%0d exp=255", duty_a); end
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL stuck_high_pending got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_reset_mid_divide();
        do_reset();
        stream(256, 64, 2, 64);
        checks++;
        if (duty_a !== 8'd64) begin failures++; $display("FAIL pre_reset_duty got=%0d exp=64", duty_a); end
        // Third rise: its sample is in the divider when reset hits.
        pwm = 1'b1;
        tick(6);
        rst_n = 1'b0;
        pwm   = 1'b0;
        #1;
        checks++;
        if (duty_a !== 8'd0) begin failures++; $display("FAIL midrst_duty got=%0d exp=0", duty_a); end
        checks++;
        if (per_a !== 24'd0) begin failures++; $display("FAIL midrst_period got=%0d exp=0", per_a); end
        checks++;
        if (valid_a !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%0d exp=0", valid_a); end
        checks++;
        if (stuck_a !== 1'b0) begin failures++; $display("FAIL midrst_stuck got=%0d exp=0", stuck_a); end
        tick(3);
        rst_n   = 1'b1;
        in_meas = 1'b0;
        free_at = 0;
        stream(256, 64, 3, 64);
        tick(30);
        checks++;
        if (sb.size() != 0) begin failures++; $display("FAIL postrst_pending got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        cyc      = 0;
        sel_b    = 1'b0;
        rst_n    = 1'b0;
        pwm      = 1'b0;
        in_meas  = 1'b0;
        free_at  = 0;
        rel_cyc  = 0;
        test_reset();
        test_duty_quarter();
        test_duty_half();
        test_long_period();
        test_back_to_back();
        test_stuck_low();
        test_stuck_high();
        test_reset_mid_divide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
